// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer countdown core: state encoding,
// BCD digit limits and the nibble-wise increment/decrement helpers.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // Two-digit BCD +1 that wraps to 00 past {tens_max, 9}; never carries out.
    function automatic logic [7:0] bcd_pair_inc(input logic [7:0] v, input logic [3:0] tens_max);
        logic [7:0] res;
        if (v[3:0] != DIGIT_MAX)
            res = {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] == tens_max)
            res = 8'h00;
        else
            res = {v[7:4] + 4'd1, 4'd0};
        return res;
    endfunction

    function automatic logic [15:0] bcd_time_dec(input logic [15:0] v);
        logic [3:0] s0;
        logic [3:0] s1;
        logic [3:0] m0;
        logic [3:0] m1;
        s0 = v[3:0];
        s1 = v[7:4];
        m0 = v[11:8];
        m1 = v[15:12];
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = DIGIT_MAX;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = SEC_TENS_MAX;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = DIGIT_MAX;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICK_DIV cycles,
// with hold (enable low) and synchronous clear.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    assign o_tick = i_en && (r_count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer countdown core: button-set BCD MM:SS value, once-per-second
// countdown, and a self-clearing alarm at 00:00.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int ALARM_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btn_start,
    input  logic        i_btn_clear,
    input  logic        i_btn_min,
    input  logic        i_btn_sec,
    output logic [15:0] o_bcd,
    output logic        o_running,
    output logic        o_alarm
);

    localparam int ACW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_TICKS - 1);

    state_t          r_state;
    logic [15:0]     r_bcd;
    logic [ACW-1:0]  r_alarm_cnt;
    logic            r_running;
    logic            r_alarm;

    logic            w_tick;
    logic            w_presc_en;
    logic            w_presc_clr;
    logic [15:0]     w_dec;

    // Holding the prescaler at 0 throughout IDLE makes RUN-from-IDLE start
    // from a fresh count; ALARM entry always lands on a wrap, so it is 0 too.
    assign w_presc_en  = (r_state == RUN) || (r_state == ALARM);
    assign w_presc_clr = (r_state == IDLE);
    assign w_dec       = bcd_time_dec(r_bcd);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_presc_en),
        .i_clr  (w_presc_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bcd       <= 16'h0000;
            r_alarm_cnt <= '0;
            r_running   <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_btn_clear) begin
                        r_bcd <= 16'h0000;
                    end else if (i_btn_start) begin
                        if (r_bcd != 16'h0000) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end else begin
                        if (i_btn_min)
                            r_bcd[15:8] <= bcd_pair_inc(r_bcd[15:8], DIGIT_MAX);
                        if (i_btn_sec)
                            r_bcd[7:0] <= bcd_pair_inc(r_bcd[7:0], SEC_TENS_MAX);
                    end
                end
                RUN: begin
                    if (i_btn_clear) begin
                        r_state   <= IDLE;
                        r_bcd     <= 16'h0000;
                        r_running <= 1'b0;
                    end else if (i_btn_start) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end else if (w_tick) begin
                        r_bcd <= w_dec;
                        if (w_dec == 16'h0000) begin
                            r_state     <= ALARM;
                            r_running   <= 1'b0;
                            r_alarm     <= 1'b1;
                            r_alarm_cnt <= '0;
                        end
                    end
                end
                PAUSE: begin
                    if (i_btn_clear) begin
                        r_state <= IDLE;
                        r_bcd   <= 16'h0000;
                    end else if (i_btn_start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                ALARM: begin
                    r_bcd <= 16'h0000;
                    if (i_btn_clear || i_btn_start) begin
                        r_state <= IDLE;
                        r_alarm <= 1'b0;
                    end else if (w_tick) begin
                        if (r_alarm_cnt == ALARM_LAST) begin
                            r_state <= IDLE;
                            r_alarm <= 1'b0;
                        end else begin
                            r_alarm_cnt <= r_alarm_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_alarm   <= 1'b0;
                end
            endcase
        end
    end

    assign o_bcd     = r_bcd;
    assign o_running = r_running;
    assign o_alarm   = r_alarm;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed scoreboard bench for egg_timer_ctrl with TICK_DIV=4, ALARM_TICKS=3.
module tb_egg_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btnStart = 1'b0;
    logic        btnClear = 1'b0;
    logic        btnMin   = 1'b0;
    logic        btnSec   = 1'b0;
    logic [15:0] bcd;
    logic        running;
    logic        alarm;

    typedef struct {
        string       tag;
        logic [15:0] bcd;
        logic        running;
        logic        alarm;
    } exp_t;

    exp_t expQ[$];
    int   nVec  = 0;
    int   nFail = 0;

    egg_timer_ctrl #(
        .TICK_DIV    (4),
        .ALARM_TICKS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_start (btnStart),
        .i_btn_clear (btnClear),
        .i_btn_min   (btnMin),
        .i_btn_sec   (btnSec),
        .o_bcd       (bcd),
        .o_running   (running),
        .o_alarm     (alarm)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic m, input logic sc);
        btnStart = s;
        btnClear = c;
        btnMin   = m;
        btnSec   = sc;
        cycles(1);
        btnStart = 1'b0;
        btnClear = 1'b0;
        btnMin   = 1'b0;
        btnSec   = 1'b0;
    endtask

    task automatic expectState(input string tag, input logic [15:0] b, input logic r, input logic a);
        exp_t e;
        e.tag = tag;
        e.bcd = b;
        e.running = r;
        e.alarm = a;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            nVec++;
            nFail++;
            $display("[TB] FAIL scoreboard_empty: got no entry, required one");
            return;
        end
        e = expQ.pop_front();
        nVec++;
        assert (bcd === e.bcd) else begin
            nFail++;
            $error("[TB] FAIL %s.bcd: got %h required %h", e.tag, bcd, e.bcd);
        end
        nVec++;
        assert (running === e.running) else begin
            nFail++;
            $error("[TB] FAIL %s.running: got %b required %b", e.tag, running, e.running);
        end
        nVec++;
        assert (alarm === e.alarm) else begin
            nFail++;
            $error("[TB] FAIL %s.alarm: got %b required %b", e.tag, alarm, e.alarm);
        end
    endtask

    initial begin
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        expectState("reset", 16'h0000, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectState("start_at_zero", 16'h0000, 1'b0, 1'b0);
        checkOutput();

        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("set_0203", 16'h0203, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectState("run_0203", 16'h0203, 1'b1, 1'b0);
        checkOutput();
        cycles(3);
        expectState("pre_tick", 16'h0203, 1'b1, 1'b0);
        checkOutput();
        cycles(1);
        expectState("first_dec", 16'h0202, 1'b1, 1'b0);
        checkOutput();
        cycles(12);
        expectState("borrow_0159", 16'h0159, 1'b1, 1'b0);
        checkOutput();

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        expectState("clear_in_run", 16'h0000, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectState("run_0001", 16'h0001, 1'b1, 1'b0);
        checkOutput();
        cycles(4);
        expectState("alarm_on", 16'h0000, 1'b0, 1'b1);
        checkOutput();
        cycles(11);
        expectState("alarm_held", 16'h0000, 1'b0, 1'b1);
        checkOutput();
        cycles(1);
        expectState("alarm_done", 16'h0000, 1'b0, 1'b0);
        checkOutput();

        repeat (61) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectState("sec_wrap", 16'h0001, 1'b0, 1'b0);
        checkOutput();
        repeat (100) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        expectState("min_wrap", 16'h0001, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expectState("min_sec_same", 16'h0101, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectState("paused", 16'h0010, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        cycles(19);
        expectState("pause_hold", 16'h0010, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        expectState("resume", 16'h0010, 1'b1, 1'b0);
        checkOutput();
        cycles(1);
        expectState("resume_wait", 16'h0010, 1'b1, 1'b0);
        checkOutput();
        cycles(1);
        expectState("resume_dec", 16'h0009, 1'b1, 1'b0);
        checkOutput();

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        expectState("start_clear", 16'h0000, 1'b0, 1'b0);
        checkOutput();

        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(2);
        #2;
        rst = 1'b1;
        #1;
        expectState("async_reset", 16'h0000, 1'b0, 1'b0);
        checkOutput();
        #1;
        rst = 1'b0;
        cycles(8);
        expectState("post_reset_idle", 16'h0000, 1'b0, 1'b0);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/egg_timer_ctrl.md
Name: egg_timer_ctrl

Overview:
Countdown core of the egg timer. It holds a BCD MM:SS value that the user sets with button pulses and counts it down once per second. It raises an alarm at 00:00. Its 16-bit BCD output drives the 7-segment display multiplexer directly downstream.

Parameters:
TICK_DIV, 100_000_000, clk cycles per 1 s tick (sims use 4)
ALARM_TICKS, 10, number of ticks the alarm stays asserted before auto-return to IDLE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_start  in  1  single-cycle pulse, already debounced/edge-detected; start/pause/resume/ack
btn_clear  in  1  single-cycle pulse; clear to 00:00, abort
btn_min  in  1  single-cycle pulse; +1 minute (IDLE only)
btn_sec  in  1  single-cycle pulse; +1 second (IDLE only)
bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}, registered
running  out  1  high in RUN
alarm  out  1  high in ALARM

Behaviour:
- Reset (async, rst=1): state=IDLE, bcd=16'h0000, prescaler=0, alarm_cnt=0, running=0, alarm=0.
- Digit ranges: sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-9. bcd never holds a non-BCD nibble or sec_tens>5.
- Prescaler: counts 0..TICK_DIV-1 in RUN and ALARM. tick = (count==TICK_DIV-1), then wraps to 0. Holds its value in PAUSE. Forced to 0 in IDLE and on entry to RUN-from-IDLE and to ALARM.
- Per-cycle priority: btn_clear > btn_start > btn_min/btn_sec. btn_min and btn_sec in the same cycle both apply.
- IDLE:
  - btn_min: minutes +1 BCD, 99 wraps to 00.
  - btn_sec: seconds +1 BCD, 59 wraps to 00, no carry into minutes.
  - btn_clear: bcd=0000.
  - btn_start with bcd!=0000: go to RUN.
  - btn_start with bcd==0000: ignored.
- RUN:
  - On tick, decrement bcd by 1 s with borrow chain: sec_ones 0 becomes 9 and borrows; sec_tens 0 becomes 5 and borrows; min_ones 0 becomes 9 and borrows.
  - If the decrement yields 0000: go to ALARM in the same edge, and bcd=0000 on that edge.
  - btn_start: go to PAUSE; bcd is unchanged even if a tick coincides (tick discarded).
  - btn_clear: go to IDLE, bcd=0000.
  - btn_min/btn_sec: ignored.
- PAUSE:
  - bcd and prescaler frozen.
  - btn_start: go to RUN; prescaler resumes from its held value.
  - btn_clear: go to IDLE, bcd=0000.
  - btn_min/btn_sec: ignored.
- ALARM:
  - bcd=0000. alarm_cnt increments on each tick.
  - When alarm_cnt reaches ALARM_TICKS-1 and a tick occurs: go to IDLE.
  - btn_start or btn_clear: go to IDLE immediately.
  - alarm_cnt cleared on entry.
- running and alarm are registered decodes of state, valid on the same edge the state changes.
- Latency: the first decrement occurs TICK_DIV cycles after the edge that samples btn_start in IDLE.
- Reset asserted mid-count returns everything to reset values asynchronously. Counting resumes only after a new setup.
- Arithmetic: all digit arithmetic uses 4-bit nibbles. No binary-to-BCD conversion is permitted.

Decomposition:
- Shared package egg_timer_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3
  - digit limit constants: SEC_TENS_MAX=5, DIGIT_MAX=9
- One natural sub-module, tick_prescaler: a parameterised TICK_DIV counter with enable (hold) and sync clear, producing tick.
- The FSM, BCD increment/decrement, and alarm counter stay in egg_timer_ctrl.

Test Plan (TICK_DIV=4, ALARM_TICKS=3):
- Reset released, no buttons -> bcd=0000, running=0, alarm=0; btn_start pulse -> state stays IDLE, running=0.
- 2x btn_min, 3x btn_sec, btn_start -> bcd=0203, running=1 on next edge; after 4 cycles bcd=0202; after 12 further cycles bcd=0159 (borrow).
- Set 0001, start -> 4 cycles later bcd=0000 and alarm=1 on the same edge; after 3 ticks (12 cycles) alarm=0, state IDLE.
- From IDLE, btn_sec x61 -> bcd=0001 (59 wrap); btn_min x100 -> bcd=0001 (99 wrap).
- Run 0010, btn_start after 2 cycles -> PAUSE, bcd=0010 held 20 cycles; btn_start -> first decrement to 0009 exactly 2 cycles later (prescaler resumed).
- btn_start and btn_clear in the same cycle during RUN -> IDLE, bcd=0000. rst pulse mid-RUN -> immediate bcd=0000, running=0.
